hires_pixel_sequencer: RTL and testbench
========================================

Name: hires_pixel_sequencer

Overview:
- Consumes the byte pair (hires_pixel_data, hires_color_data) produced each phi half-cycle by the hires address generator.
- Serialises each pair into eight 80-column pixels, two clk_dot4x ticks per pixel, and outputs a 4-bit colour index to the palette/output mux.
- Handles attribute decode for text mode (blink, underline, reverse) and the three bitmap modes.
- Holds one half-cycle of pipeline buffering between the fetch stage and the shifter.

Parameters:
- BLINK_BIT, 5, index of the frame-counter bit used as the blink phase (period 2^(BLINK_BIT+1) frames).

Ports:
- clk_dot4x  in  1  4x dot clock; only clock.
- rst_n  in  1  asynchronous, active-low reset.
- clk_phi  in  1  phi level, used to identify the current half-cycle.
- phi_phase_start  in  16  one-hot phase marker, 16 ticks per phi half-cycle.
- cycle_num  in  7  VIC cycle number.
- rc  in  3  row counter; used for the underline row.
- hires_mode  in  2  00 text, 01 2-colour bitmap, 10 4-colour bitmap, 11 16-colour bitmap.
- hires_enabled  in  1  80-column mode enable.
- hires_pixel_data  in  8  pixel byte; valid at phase 10.
- hires_color_data  in  8  colour/attribute byte, or first pixel byte in modes 10/11; valid at phase 10.
- hires_bg_color  in  4  text-mode background index.
- palette4  in  16  four 4-bit indices for mode 10; entry n is bits [4n+3:4n].
- frame_tick  in  1  one-tick pulse per frame.
- hires_pixel_color  out  4  current pixel colour index.
- hires_active  out  1  1 while shifting a fetched byte.

Behaviour:
- Fetch window: identical to the address generator's.
  - cycle 14 with clk_phi=1, cycles 15..53, or cycle 54 with clk_phi=0.
  - Evaluated at phi_phase_start[10].
- Capture stage: at phase 10, if the fetch window is active and hires_enabled=1, latch into pend_pix, pend_col, pend_mode and pend_valid=1. Otherwise set pend_valid=0.
- Load stage: at phase 0 of the next half-cycle:
  - shift_pix <= pend_pix, shift_col <= pend_col, shift_mode <= pend_mode.
  - hires_active <= pend_valid.
  - A mode change therefore affects only bytes captured after the change; a byte already in flight keeps its mode.
- Shift stage: pixel slot k = 0..7 is driven on phases 2k and 2k+1. Latency from data-valid (phase 10) to the first pixel is 6 ticks.
- Mode 00, text:
  - bit = shift_pix[7-k].
  - Reverse (col[6]) XORs bit.
  - Underline (col[5]) with rc==7 forces bit=1, applied before reverse.
  - Blink (col[4]) with blink_phase=1 forces bit=0, applied last.
  - bit=1 -> col[3:0]; bit=0 -> hires_bg_color.
  - col[7] (alternate charset) is ignored here.
- Mode 01: bit = shift_pix[7-k]; 1 -> col[7:4], 0 -> col[3:0].
- Mode 10: 16-bit word W = {col, pix}; pixel k uses W[15-2k : 14-2k] as an index into palette4.
- Mode 11:
  - W as above; pixel pair k/2 uses nibble W[15-4(k>>1) : 12-4(k>>1)] directly.
  - Each nibble is shown for two pixel slots, giving 320-wide double pixels.
- Inactive output: when hires_active=0, hires_pixel_color = 4'h0.
- Blink counter: 8-bit, increments on frame_tick and wraps 255->0. blink_phase = counter[BLINK_BIT].
- Output register: hires_pixel_color is registered, so the pipeline adds one tick; all slot timings above refer to the registered output.
- Reset: rst_n low asynchronously clears the following to 0.
  - Outputs: hires_pixel_color, hires_active.
  - State: pend_*, shift_*, blink counter.
  - Reset released mid-line: output stays 0 until the next capture/load pair completes. No partial byte is emitted.
- Simultaneous events:
  - Capture at phase 10 of half N and load at phase 0 of half N+1 never collide.
  - frame_tick coinciding with a pixel slot changes blink_phase from the next tick onward.

Test Plan:
- Mode 00: pix=8'hA5, col=8'h0E, bg=4'h6, rc=3 -> slots 0..7 output E,6,E,6,6,E,6,E, each 2 ticks, first slot 6 ticks after phase 10 of capture (+1 register).
- Mode 00 attributes: col=8'h6E with pix=8'h00, rc=7 -> underline then reverse gives all bg (6). Same with rc=2 -> all E. Set blink (col=8'h1E) with counter bit5=1 -> all 6.
- Mode 10: col=8'h1B, pix=8'hE4, palette4=16'hFA52 -> indices 0,1,2,3,3,2,1,0 -> 2,5,A,F,F,A,5,2.
- Mode 11: col=8'h12, pix=8'h34 -> 1,1,2,2,3,3,4,4. Switch to mode 01 between capture and load -> in-flight byte still rendered as mode 11.
- Window edges: cycle 14 phi=0 -> hires_active stays 0; cycle 14 phi=1 -> first byte emitted. Cycle 54 phi=1 -> no capture, output 0 after the last byte.
- Assert rst_n low at pixel slot 3 -> output 0 immediately. Release mid half-cycle -> output 0 until the next valid load; blink counter restarts at 0.

Source files
------------

// File: rtl/hires_pixel_sequencer.sv
// 80-column pixel sequencer: captures the hires byte pair at phase 10, loads it into
// the shifter at phase 0 of the next half-cycle, and emits a registered 4-bit colour index.
module hires_pixel_sequencer #(
  parameter int BLINK_BIT = 5
) (
  input  logic        clk_dot4x,
  input  logic        rst_n,
  input  logic        clk_phi,
  input  logic [15:0] phi_phase_start,
  input  logic [6:0]  cycle_num,
  input  logic [2:0]  rc,
  input  logic [1:0]  hires_mode,
  input  logic        hires_enabled,
  input  logic [7:0]  hires_pixel_data,
  input  logic [7:0]  hires_color_data,
  input  logic [3:0]  hires_bg_color,
  input  logic [15:0] palette4,
  input  logic        frame_tick,
  output logic [3:0]  hires_pixel_color,
  output logic        hires_active
);

  logic       in_window;
  logic [3:0] phase_idx;
  logic [3:0] prev_phase;
  logic [2:0] slot;

  logic [7:0] pend_pix;
  logic [7:0] pend_col;
  logic [1:0] pend_mode;
  logic       pend_valid;

  logic [7:0] shift_pix;
  logic [7:0] shift_col;
  logic [1:0] shift_mode;

  logic [7:0] blink_cnt;
  logic       blink_phase;

  logic [15:0] word;
  logic        pix_bit;
  logic        text_bit;
  logic [1:0]  pal_idx;
  logic [3:0]  pix_color;

  assign in_window = ((cycle_num == 7'd14) && clk_phi) ||
                     ((cycle_num >= 7'd15) && (cycle_num <= 7'd53)) ||
                     ((cycle_num == 7'd54) && !clk_phi);

  always_comb begin
    phase_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (phi_phase_start[i]) phase_idx = 4'(i);
    end
  end

  // The output register lags one tick, so the slot being registered now is the one
  // for the previous phase; at phase 0 that is slot 7 of the byte still in the shifter.
  assign prev_phase = phase_idx - 4'd1;
  assign slot       = prev_phase[3:1];

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      pend_pix   <= 8'h00;
      pend_col   <= 8'h00;
      pend_mode  <= 2'b00;
      pend_valid <= 1'b0;
    end else if (phi_phase_start[10]) begin
      pend_valid <= in_window && hires_enabled;
      if (in_window && hires_enabled) begin
        pend_pix  <= hires_pixel_data;
        pend_col  <= hires_color_data;
        pend_mode <= hires_mode;
      end
    end
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      shift_pix    <= 8'h00;
      shift_col    <= 8'h00;
      shift_mode   <= 2'b00;
      hires_active <= 1'b0;
    end else if (phi_phase_start[0]) begin
      shift_pix    <= pend_pix;
      shift_col    <= pend_col;
      shift_mode   <= pend_mode;
      hires_active <= pend_valid;
    end
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= 8'h00;
    end else if (frame_tick) begin
      blink_cnt <= blink_cnt + 8'd1;
    end
  end

  assign blink_phase = blink_cnt[BLINK_BIT];
  assign word        = {shift_col, shift_pix};
  assign pix_bit     = shift_pix[3'd7 - slot];

  // Text attributes: underline forces on, reverse inverts, blink forces off last.
  always_comb begin
    text_bit = pix_bit;
    if (shift_col[5] && (rc == 3'd7)) text_bit = 1'b1;
    if (shift_col[6]) text_bit = ~text_bit;
    if (shift_col[4] && blink_phase) text_bit = 1'b0;
  end

  assign pal_idx = word[4'd15 - {slot, 1'b0} -: 2];

  always_comb begin
    pix_color = 4'h0;
    case (shift_mode)
      2'b00: pix_color = text_bit ? shift_col[3:0] : hires_bg_color;
      2'b01: pix_color = pix_bit ? shift_col[7:4] : shift_col[3:0];
      2'b10: pix_color = palette4[{pal_idx, 2'b00} +: 4];
      2'b11: pix_color = word[4'd15 - {slot[2:1], 2'b00} -: 4];
      default: pix_color = 4'h0;
    endcase
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      hires_pixel_color <= 4'h0;
    end else begin
      hires_pixel_color <= hires_active ? pix_color : 4'h0;
    end
  end

endmodule

// File: tb/tb_hires_pixel_sequencer.sv
// Directed bench for hires_pixel_sequencer: drives phi half-cycles tick by tick, logs
// the registered output, and checks hand-computed pixel sequences per scenario.
module tb_hires_pixel_sequencer;

  logic        clk_dot4x = 1'b0;
  logic        rst_n;
  logic        clk_phi;
  logic [15:0] phi_phase_start;
  logic [6:0]  cycle_num;
  logic [2:0]  rc;
  logic [1:0]  hires_mode;
  logic        hires_enabled;
  logic [7:0]  hires_pixel_data;
  logic [7:0]  hires_color_data;
  logic [3:0]  hires_bg_color;
  logic [15:0] palette4;
  logic        frame_tick;
  logic [3:0]  hires_pixel_color;
  logic        hires_active;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  logic [3:0] log_col [0:4095];
  logic       log_act [0:4095];

  hires_pixel_sequencer #(.BLINK_BIT(5)) dut (
    .clk_dot4x         (clk_dot4x),
    .rst_n             (rst_n),
    .clk_phi           (clk_phi),
    .phi_phase_start   (phi_phase_start),
    .cycle_num         (cycle_num),
    .rc                (rc),
    .hires_mode        (hires_mode),
    .hires_enabled     (hires_enabled),
    .hires_pixel_data  (hires_pixel_data),
    .hires_color_data  (hires_color_data),
    .hires_bg_color    (hires_bg_color),
    .palette4          (palette4),
    .frame_tick        (frame_tick),
    .hires_pixel_color (hires_pixel_color),
    .hires_active      (hires_active)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  // Drives phases p_lo..p_hi of one half-cycle; inputs change 1ns after each edge and
  // the output seen 1ns after each edge is logged at index t.
  task automatic run_phases(input logic [6:0] cyc, input logic phi, input logic [7:0] pix,
                            input logic [7:0] col, input logic [1:0] mode,
                            input logic [1:0] mode_late, input int p_lo, input int p_hi);
    for (int p = p_lo; p <= p_hi; p++) begin
      phi_phase_start  = 16'h0001 << p;
      cycle_num        = cyc;
      clk_phi          = phi;
      hires_pixel_data = pix;
      hires_color_data = col;
      hires_mode       = (p > 10) ? mode_late : mode;
      @(posedge clk_dot4x);
      #1;
      if (t < 4096) begin
        log_col[t] = hires_pixel_color;
        log_act[t] = hires_active;
      end
      t++;
    end
  endtask

  task automatic half(input logic [6:0] cyc, input logic phi, input logic [7:0] pix,
                      input logic [7:0] col, input logic [1:0] mode, input logic [1:0] mode_late);
    run_phases(cyc, phi, pix, col, mode, mode_late, 0, 15);
  endtask

  task automatic pulse_frames(input int n);
    phi_phase_start = 16'h0000;
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge clk_dot4x);
      #1;
      frame_tick = 1'b0;
      @(posedge clk_dot4x);
      #1;
    end
  endtask

  task automatic test_reset();
    int h0;
    rst_n = 1'b0;
    h0 = t;
    half(7'd20, 1'b1, 8'hFF, 8'hF1, 2'b01, 2'b01);
    n_checks++;
    if (hires_pixel_color !== 4'h0 || hires_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got color=%h active=%b expected 0/0", hires_pixel_color, hires_active);
    end
    #1 rst_n = 1'b1;
    half(7'd0, 1'b0, 8'h00, 8'h00, 2'b01, 2'b01);
    half(7'd0, 1'b0, 8'h00, 8'h00, 2'b01, 2'b01);
    for (int j = 0; j < 48; j++) begin
      n_checks++;
      if (log_col[h0 + j] !== 4'h0 || log_act[h0 + j] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got color=%h active=%b expected 0/0", j, log_col[h0 + j], log_act[h0 + j]);
      end
    end
  endtask

  task automatic test_text_mode();
    int h0;
    logic [31:0] pat;
    logic [3:0]  exp;
    pat = 32'hE6E66E6E;
    rc  = 3'd3;
    h0  = t;
    half(7'd20, 1'b1, 8'hA5, 8'h0E, 2'b00, 2'b00);
    half(7'd0, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00);
    half(7'd0, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00);
    for (int j = 0; j < 16; j++) begin
      exp = pat[31 - 4 * (j >> 1) -: 4];
      n_checks++;
      if (log_col[h0 + 17 + j] !== exp) begin
        n_fail++;
        $display("FAIL text_pixel[%0d]: got %h expected %h", j, log_col[h0 + 17 + j], exp);
      end
    end
    n_checks++;
    if (log_col[h0 + 16] !== 4'h0) begin
      n_fail++;
      $display("FAIL text_latency: got %h expected 0 before first slot", log_col[h0 + 16]);
    end
    n_checks++;
    if (log_act[h0 + 16] !== 1'b1 || log_act[h0 + 32] !== 1'b0 || log_col[h0 + 33] !== 4'h0) begin
      n_fail++;
      $display("FAIL text_active: got act=%b/%b col_after=%h expected 1/0/0",
               log_act[h0 + 16], log_act[h0 + 32], log_col[h0 + 33]);
    end
  endtask

  task automatic test_text_attrs();
    logic [7:0] cols [3];
    logic [7:0] pixs [3];
    logic [2:0] rcs  [3];
    logic [3:0] exps [3];
    int h0;
    cols = '{8'h6E, 8'h6E, 8'h1E};
    pixs = '{8'h00, 8'h00, 8'hFF};
    rcs  = '{3'd7, 3'd2, 3'd3};
    exps = '{4'h6, 4'hE, 4'h6};
    for (int i = 0; i < 3; i++) begin
      if (i == 2) pulse_frames(32);
      rc = rcs[i];
      h0 = t;
      half(7'd20, 1'b1, pixs[i], cols[i], 2'b00, 2'b00);
      half(7'd0, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00);
      half(7'd0, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00);
      for (int j = 0; j < 16; j++) begin
        n_checks++;
        if (log_col[h0 + 17 + j] !== exps[i]) begin
          n_fail++;
          $display("FAIL text_attr%0d[%0d]: got %h expected %h", i, j, log_col[h0 + 17 + j], exps[i]);
        end
      end
    end
    rc = 3'd3;
  endtask

  task automatic test_bitmap_4color();
    int h0;
    logic [31:0] pat;
    logic [3:0]  exp;
    pat = 32'h25AFFA52;
    h0  = t;
    half(7'd30, 1'b0, 8'hE4, 8'h1B, 2'b10, 2'b10);
    half(7'd0, 1'b0, 8'h00, 8'h00, 2'b10, 2'b10);
    half(7'd0, 1'b0, 8'h00, 8'h00, 2'b10, 2'b10);
    for (int j = 0; j < 16; j++) begin
      exp = pat[31 - 4 * (j >> 1) -: 4];
      n_checks++;
      if (log_col[h0 + 17 + j] !== exp) begin
        n_fail++;
        $display("FAIL mode10_pixel[%0d]: got %h expected %h", j, log_col[h0 + 17 + j], exp);
      end
    end
  endtask

  task automatic test_bitmap_16color_inflight();
    int h0;
    logic [31:0] pat;
    logic [3:0]  exp;
    pat = 32'h11223344;
    h0  = t;
    half(7'd40, 1'b1, 8'h34, 8'h12, 2'b11, 2'b01);
    half(7'd0, 1'b0, 8'h00, 8'h00, 2'b01, 2'b01);
    half(7'd0, 1'b0, 8'h00, 8'h00, 2'b01, 2'b01);
    for (int j = 0; j < 16; j++) begin
      exp = pat[31 - 4 * (j >> 1) -: 4];
      n_checks++;
      if (log_col[h0 + 17 + j] !== exp) begin
        n_fail++;
        $display("FAIL mode11_inflight[%0d]: got %h expected %h", j, log_col[h0 + 17 + j], exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int h0;
    logic [31:0] pat_a;
    logic [31:0] pat_b;
    logic [3:0]  exp;
    pat_a = 32'h3333CCCC;
    pat_b = 32'h5AAAAAA5;
    h0    = t;
    half(7'd20, 1'b1, 8'hF0, 8'h3C, 2'b01, 2'b01);
    half(7'd21, 1'b0, 8'h81, 8'h5A, 2'b01, 2'b01);
    half(7'd0, 1'b0, 8'h00, 8'h00, 2'b01, 2'b01);
    half(7'd0, 1'b0, 8'h00, 8'h00, 2'b01, 2'b01);
    for (int j = 0; j < 32; j++) begin
      exp = (j < 16) ? pat_a[31 - 4 * (j >> 1) -: 4] : pat_b[31 - 4 * ((j - 16) >> 1) -: 4];
      n_checks++;
      if (log_col[h0 + 17 + j] !== exp || log_act[h0 + 16 + j] !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h act=%b expected %h act=1",
                 j, log_col[h0 + 17 + j], log_act[h0 + 16 + j], exp);
      end
    end
  endtask

  task automatic test_window_edges();
    int h0;
    h0 = t;
    half(7'd14, 1'b0, 8'hFF, 8'hF1, 2'b01, 2'b01);
    half(7'd14, 1'b1, 8'hFF, 8'hF1, 2'b01, 2'b01);
    half(7'd54, 1'b0, 8'hFF, 8'hF1, 2'b01, 2'b01);
    half(7'd54, 1'b1, 8'hFF, 8'hF1, 2'b01, 2'b01);
    half(7'd0, 1'b0, 8'h00, 8'h00, 2'b01, 2'b01);
    for (int j = 16; j < 32; j++) begin
      n_checks++;
      if (log_act[h0 + j] !== 1'b0 || log_col[h0 + j] !== 4'h0) begin
        n_fail++;
        $display("FAIL window_c14_phi0[%0d]: got act=%b col=%h expected 0/0", j, log_act[h0 + j], log_col[h0 + j]);
      end
    end
    for (int j = 33; j < 65; j++) begin
      n_checks++;
      if (log_col[h0 + j] !== 4'hF) begin
        n_fail++;
        $display("FAIL window_emit[%0d]: got %h expected f", j, log_col[h0 + j]);
      end
    end
    for (int j = 65; j < 80; j++) begin
      n_checks++;
      if (log_act[h0 + j] !== 1'b0 || log_col[h0 + j] !== 4'h0) begin
        n_fail++;
        $display("FAIL window_c54_phi1[%0d]: got act=%b col=%h expected 0/0", j, log_act[h0 + j], log_col[h0 + j]);
      end
    end
  endtask

  task automatic test_reset_mid_line();
    int h0;
    int h1;
    int h2;
    logic [31:0] pat;
    logic [3:0]  exp;
    pat = 32'hE6E66E6E;
    rc  = 3'd3;
    h0  = t;
    half(7'd20, 1'b1, 8'hA5, 8'h1E, 2'b00, 2'b00);
    run_phases(7'd0, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 7);
    n_checks++;
    if (log_col[h0 + 23] !== 4'h6) begin
      n_fail++;
      $display("FAIL midreset_pre_slot3: got %h expected 6", log_col[h0 + 23]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (hires_pixel_color !== 4'h0 || hires_active !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_immediate: got color=%h active=%b expected 0/0", hires_pixel_color, hires_active);
    end
    run_phases(7'd0, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 8, 15);
    run_phases(7'd20, 1'b1, 8'hA5, 8'h1E, 2'b00, 2'b00, 0, 4);
    rst_n = 1'b1;
    h1 = t;
    run_phases(7'd20, 1'b1, 8'hA5, 8'h1E, 2'b00, 2'b00, 5, 15);
    h2 = t;
    half(7'd0, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00);
    half(7'd0, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00);
    for (int j = 0; j <= 11; j++) begin
      n_checks++;
      if (log_col[h1 + j] !== 4'h0) begin
        n_fail++;
        $display("FAIL midreset_hold0[%0d]: got %h expected 0", j, log_col[h1 + j]);
      end
    end
    for (int j = 0; j < 16; j++) begin
      exp = pat[31 - 4 * (j >> 1) -: 4];
      n_checks++;
      if (log_col[h2 + 1 + j] !== exp) begin
        n_fail++;
        $display("FAIL midreset_blink_restart[%0d]: got %h expected %h", j, log_col[h2 + 1 + j], exp);
      end
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    clk_phi          = 1'b0;
    phi_phase_start  = 16'h0000;
    cycle_num        = 7'd0;
    rc               = 3'd3;
    hires_mode       = 2'b00;
    hires_enabled    = 1'b1;
    hires_pixel_data = 8'h00;
    hires_color_data = 8'h00;
    hires_bg_color   = 4'h6;
    palette4         = 16'hFA52;
    frame_tick       = 1'b0;

    test_reset();
    test_text_mode();
    test_text_attrs();
    test_bitmap_4color();
    test_bitmap_16color_inflight();
    test_back_to_back();
    test_window_edges();
    test_reset_mid_line();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
